muldiv_ctrl: RTL and testbench

- Sequences the multiply/divide datapath feeding the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a fixed-latency multiplier or an iterative radix-2 divider.
- Stalls the pipeline while busy, then presents the 64-bit result with a one-cycle result_ok strobe that commits it to HI/LO.
- Supports cancellation by exception flush.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_ctrl_if.sv | 25 ++
 rtl/muldiv_ctrl_div_core.sv | 58 +++++
 rtl/muldiv_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide controller.
//   op_e       - EX-stage operation encodings (MULT, MULTU, DIV, DIVU)
//   state_e    - controller FSM states
//   DIV_ITER   - restoring divider iterations (equals data width)
//   DIV0_QUOT  - quotient reported for a zero divisor
//   helpers    - op classification and operand magnitude
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        DIV_FIX,
        DONE
    } state_e;

    localparam int unsigned DIV_ITER  = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Absolute value when the operand is treated as signed, raw value otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage <-> multiply/divide controller handshake.
//   start/op/a/b/flush : request from the pipeline (master drives)
//   stall_o/busy       : pipeline hold and activity indication (slave drives)
//   result/result_ok   : {hi,lo} value and one-cycle HI/LO commit strobe
interface muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall_o;
    logic        busy;
    logic [63:0] result;
    logic        result_ok;

    modport master (
        output start, op, a, b, flush,
        input  stall_o, busy, result, result_ok
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall_o, busy, result, result_ok
    );
endinterface

// File: rtl/muldiv_ctrl_div_core.sv
// div_core: unsigned 32-bit iterative restoring divider, one quotient bit per step.
//   clk, rst           : clock, synchronous active-high reset
//   load               : capture dividend/divisor, clear remainder and counter
//   step               : perform one restoring iteration
//   dividend, divisor  : unsigned operands (sampled on load)
//   done               : high while the step being performed is the final one,
//                        so quot/rem are final on the following cycle
//   quot, rem          : quotient and remainder registers
module div_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    localparam int unsigned CW = $clog2(DIV_ITER);

    logic [CW-1:0] cnt;
    logic [31:0]   dvsr;
    logic [32:0]   rem_sh;
    logic          ge;
    logic [31:0]   rem_sub;

    // rem_sh can exceed 32 bits only when it is already >= divisor, so the
    // subtraction result and the restore path both fit back into 32 bits.
    always_comb begin
        rem_sh  = {rem, quot[31]};
        ge      = rem_sh >= {1'b0, dvsr};
        rem_sub = rem_sh[31:0] - dvsr;
        done    = step && (cnt == CW'(DIV_ITER - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dvsr <= '0;
            quot <= '0;
            rem  <= '0;
        end else if (load) begin
            cnt  <= '0;
            dvsr <= divisor;
            quot <= dividend;
            rem  <= '0;
        end else if (step) begin
            cnt  <= cnt + 1'b1;
            quot <= {quot[30:0], ge};
            rem  <= ge ? rem_sub : rem_sh[31:0];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences MULT/MULTU/DIV/DIVU for the HI/LO register pair.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : muldiv_ctrl_if.slave
//                start/op/a/b sampled in IDLE or DONE when flush is low;
//                flush cancels any operation (no result_ok, result kept);
//                stall_o holds IF..EX; busy = not IDLE;
//                result = {hi,lo}; result_ok pulses for one cycle in DONE.
// Parameter MUL_LAT: cycles spent in MUL_RUN (>= 1).
// Optional build macro MULDIV_FAST_DIV_EN: a divide whose divisor magnitude
// exceeds the dividend magnitude (divisor non-zero) completes at T+1 with
// lo = 0, hi = a.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);

    localparam int unsigned MCW = $clog2(MUL_LAT) + 1;

    state_e         state_q, state_d;
    op_e            op_in;
    op_e            op_q;
    logic [31:0]    a_q, b_q;
    logic           neg_quot, neg_rem;
    logic [MCW-1:0] mul_cnt;
    logic [63:0]    result_q, res_d;
    logic           res_load;
    logic           start_fire;
    logic           mul_last;

    logic signed [63:0] mul_a, mul_b, product;

    logic        div_load, div_done;
    logic [31:0] div_dvnd, div_dvsr, div_quot, div_rem;
    logic [31:0] fix_hi, fix_lo;

`ifdef MULDIV_FAST_DIV_EN
    logic fast_hit;
`endif

    always_comb begin
        op_in      = op_e'(bus.op);
        start_fire = bus.start && !bus.flush && (state_q inside {IDLE, DONE});
        div_dvnd   = mag32(bus.a, op_is_signed(op_in));
        div_dvsr   = mag32(bus.b, op_is_signed(op_in));
        div_load   = start_fire && op_is_div(op_in);
        mul_last   = (mul_cnt == MCW'(MUL_LAT - 1));
    end

`ifdef MULDIV_FAST_DIV_EN
    always_comb begin
        fast_hit = op_is_div(op_in) && (bus.b != '0) && (div_dvsr > div_dvnd);
    end
`endif

    // Low 64 bits of a 64x64 product of sign- or zero-extended operands give
    // the correct 32x32->64 result for both MULT and MULTU.
    always_comb begin
        mul_a   = {{32{op_is_signed(op_q) & a_q[31]}}, a_q};
        mul_b   = {{32{op_is_signed(op_q) & b_q[31]}}, b_q};
        product = mul_a * mul_b;
    end

    // Divide-by-zero reports the raw dividend regardless of signedness.
    always_comb begin
        if (b_q == '0) begin
            fix_hi = a_q;
            fix_lo = DIV0_QUOT;
        end else begin
            fix_hi = neg_rem  ? (~div_rem  + 32'd1) : div_rem;
            fix_lo = neg_quot ? (~div_quot + 32'd1) : div_quot;
        end
    end

    div_core u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (state_q == DIV_RUN),
        .dividend (div_dvnd),
        .divisor  (div_dvsr),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        res_load = 1'b0;
        res_d    = result_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (op_is_div(op_in)) begin
`ifdef MULDIV_FAST_DIV_EN
                            if (fast_hit) begin
                                state_d  = DONE;
                                res_load = 1'b1;
                                res_d    = {bus.a, 32'h0};
                            end else begin
                                state_d = DIV_RUN;
                            end
`else
                            state_d = DIV_RUN;
`endif
                        end else begin
                            state_d = MUL_RUN;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                MUL_RUN: begin
                    if (mul_last) begin
                        state_d  = DONE;
                        res_load = 1'b1;
                        res_d    = product;
                    end
                end
                DIV_RUN: begin
                    if (div_done) begin
                        state_d = DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    state_d  = DONE;
                    res_load = 1'b1;
                    res_d    = {fix_hi, fix_lo};
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_MULT;
            a_q      <= '0;
            b_q      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            mul_cnt  <= '0;
            result_q <= '0;
        end else begin
            if (start_fire) begin
                op_q     <= op_in;
                a_q      <= bus.a;
                b_q      <= bus.b;
                neg_quot <= op_is_signed(op_in) && (bus.a[31] ^ bus.b[31]);
                neg_rem  <= op_is_signed(op_in) && bus.a[31];
            end
            if (state_q == MUL_RUN) begin
                mul_cnt <= mul_cnt + 1'b1;
            end else begin
                mul_cnt <= '0;
            end
            if (res_load) begin
                result_q <= res_d;
            end
        end
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.result_ok = (state_q == DONE);
        bus.result    = result_q;
        bus.stall_o   = (bus.start && (state_q inside {IDLE, DONE}) && !bus.flush)
                      || (state_q inside {MUL_RUN, DIV_RUN, DIV_FIX});
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table-driven bench for muldiv_ctrl plus hand sequences for
// flush cancellation, start-with-flush, and back-to-back start in DONE.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_DIV_EN
        logic [31:0] ma;
        logic [31:0] mb;
`endif
        if (!op[1]) return MUL_LAT + 1;
`ifdef MULDIV_FAST_DIV_EN
        ma = (op == 2'd2 && a[31]) ? -a : a;
        mb = (op == 2'd2 && b[31]) ? -b : b;
        if (b != 0 && mb > ma) return 1;
`endif
        return 34;
    endfunction

    // Called in the negedge window of cycle T; returns the cycle offset at
    // which result_ok was seen (-1 on timeout) and whether stall_o dropped early.
    task automatic wait_done(output int lat, output logic stall_gap);
        lat       = -1;
        stall_gap = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.result_ok) begin
                lat = c;
                break;
            end
            if (!bus.stall_o) stall_gap = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx);
        int   lat;
        logic gap;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = vecs[idx].op;
        bus.a     = vecs[idx].a;
        bus.b     = vecs[idx].b;
        #1;
        check({nm, "/stall_at_T"}, 64'(bus.stall_o), 64'd1);
        wait_done(lat, gap);
        check({nm, "/latency"}, 64'(lat), 64'(exp_lat(vecs[idx].op, vecs[idx].a, vecs[idx].b)));
        check({nm, "/result"}, bus.result, vecs[idx].exp);
        check({nm, "/stall_in_done"}, 64'(bus.stall_o), 64'd0);
        check({nm, "/stall_gap"}, 64'(gap), 64'd0);
        @(negedge clk);
        check({nm, "/ok_one_cycle"}, 64'(bus.result_ok), 64'd0);
        check({nm, "/result_hold"}, bus.result, vecs[idx].exp);
    endtask

    initial begin
        int          lat;
        logic        gap;
        logic        seen_ok;
        logic [63:0] last_exp;

        errors = 0;
        checks = 0;

        vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3]  = '{2'd3, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF};
        vecs[4]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[5]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF};
        vecs[6]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[7]  = '{2'd1, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
        vecs[8]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[9]  = '{2'd3, 32'h0000_0007, 32'h0000_0009, 64'h0000_0007_0000_0000};
        vecs[10] = '{2'd3, 32'h0000_03E8, 32'h0000_0003, 64'h0000_0001_0000_014D};
        vecs[11] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[12] = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003};
        vecs[13] = '{2'd2, 32'h0000_0003, 32'hFFFF_FFF9, 64'h0000_0003_0000_0000};
        vecs[14] = '{2'd2, 32'hFFFF_FFFE, 32'h0000_0005, 64'hFFFF_FFFE_0000_0000};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/busy", 64'(bus.busy), 64'd0);
        check("reset/stall", 64'(bus.stall_o), 64'd0);
        check("reset/result_ok", 64'(bus.result_ok), 64'd0);
        check("reset/result", bus.result, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec(i);
        end
        last_exp = vecs[14].exp;

        // Flush at T+10 of a DIVU: IDLE at T+11, no commit, result kept.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        seen_ok   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.result_ok) seen_ok = 1'b1;
            if (c == 10) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        if (bus.result_ok) seen_ok = 1'b1;
        check("flush/idle", 64'(bus.busy), 64'd0);
        check("flush/no_ok", 64'(seen_ok), 64'd0);
        check("flush/result_kept", bus.result, last_exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        wait_done(lat, gap);
        check("after_flush/latency", 64'(lat), 64'(MUL_LAT + 1));
        check("after_flush/result", bus.result, 64'h0000_0000_0000_001E);
        @(negedge clk);

        // Start together with flush is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
        #1;
        check("start_flush/stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush/busy", 64'(bus.busy), 64'd0);
        check("start_flush/result", bus.result, 64'h0000_0000_0000_001E);

        // Back-to-back: start DIVU in the DONE cycle of a MULTU.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        wait_done(lat, gap);
        check("b2b/mul_latency", 64'(lat), 64'(MUL_LAT + 1));
        check("b2b/mul_result", bus.result, 64'h0000_0000_0000_0006);
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'd9;
        bus.b     = 32'd4;
        #1;
        check("b2b/stall_in_done", 64'(bus.stall_o), 64'd1);
        wait_done(lat, gap);
        check("b2b/div_latency", 64'(lat), 64'd34);
        check("b2b/div_result", bus.result, 64'h0000_0001_0000_0002);
        check("b2b/stall_gap", 64'(gap), 64'd0);
        @(negedge clk);
        check("b2b/idle", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
